// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment digit scanner.
//   BLANK_CODE : BCD code that the downstream decoder renders as all segments off
//   an_on/an_off : anode drive level for a given polarity (active_low=1 -> on is 0)
//   idx_width  : width of a digit index for n digits (never less than 1)
package seg_pkg;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  function automatic logic an_on(input bit active_low);
    return active_low ? 1'b0 : 1'b1;
  endfunction

  function automatic logic an_off(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Modulo-DIV free-running counter that produces the per-digit refresh tick.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (count returns to 0)
//   en    : count enable; while low the count is held at 0
//   tick  : high for one cycle when the count sits at DIV-1 (and en=1)
module refresh_prescaler #(
  parameter int DIV = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (!en || count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign tick = en && (count_reg == LAST);

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed digit scanner for a common-anode multi-digit 7-segment
// display. Feeds bcd_to_7seg with one digit per refresh slot.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset
//   bcd_in     : packed BCD value, digit 0 in bits [3:0]
//   load       : one-cycle strobe capturing bcd_in into the shadow register
//   en         : display enable (low = dark display, scan held at digit 0)
//   blank_lz   : suppress leading zeros (digit 0 always shown)
//   bcd_out    : BCD code of the digit currently lit (BLANK_CODE when dark)
//   an         : one-hot anode select, polarity set by AN_ACTIVE_LOW
//   frame_done : one-cycle pulse when the last digit's slot ends
module seg_scan_mux import seg_pkg::*; #(
  parameter int NUM_DIGITS    = 4,
  parameter int REFRESH_DIV   = 50000,
  parameter int AN_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    en,
  input  logic                    blank_lz,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IW = idx_width(NUM_DIGITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic AN_OFF = an_off(AN_ACTIVE_LOW != 0);

  logic                    tick;
  logic                    boundary;
  logic [IW-1:0]           index_reg;
  logic [4*NUM_DIGITS-1:0] shadow_reg;
  logic [4*NUM_DIGITS-1:0] display_reg;
  logic                    pending_reg;
  logic [3:0]              bcd_out_reg;
  logic [NUM_DIGITS-1:0]   an_reg;
  logic                    frame_done_reg;

  refresh_prescaler #(
    .DIV (REFRESH_DIV)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (tick)
  );

  // The boundary is the tick that ends the last digit's slot.
  assign boundary = tick && (index_reg == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index_reg <= '0;
    end else if (!en) begin
      index_reg <= '0;
    end else if (tick) begin
      index_reg <= boundary ? '0 : index_reg + IW'(1);
    end
  end

  // Shadow/display double buffer: the display only changes on a frame
  // boundary, so a frame is never drawn with a mix of old and new digits.
  // A load landing on the boundary itself bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg  <= '0;
      display_reg <= '0;
      pending_reg <= 1'b0;
    end else begin
      if (load) begin
        shadow_reg <= bcd_in;
      end
      if (boundary && load) begin
        display_reg <= bcd_in;
        pending_reg <= 1'b0;
      end else if (boundary && pending_reg) begin
        display_reg <= shadow_reg;
        pending_reg <= 1'b0;
      end else if (load) begin
        pending_reg <= 1'b1;
      end
    end
  end

  // zero_above[k]: digits NUM_DIGITS-1 down to k of the display are all 4'h0.
  // zero_above[NUM_DIGITS] is the empty run above the top digit. Only an
  // exact 4'h0 counts; codes A-F stop the run like any other nonzero digit.
  logic [3:0]            digit [NUM_DIGITS];
  logic [NUM_DIGITS:1]   zero_above;
  logic [NUM_DIGITS-1:0] blank_mask;

  assign zero_above[NUM_DIGITS] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      assign digit[gi] = display_reg[4*gi +: 4];
      if (gi == 0) begin : g_lsd
        assign blank_mask[gi] = 1'b0;
      end else begin : g_upper
        assign zero_above[gi] = (digit[gi] == 4'h0) && zero_above[gi+1];
        assign blank_mask[gi] = blank_lz && zero_above[gi];
      end
    end
  endgenerate

  logic [3:0]            cur_digit;
  logic                  cur_blank;
  logic [NUM_DIGITS-1:0] cur_onehot;

  always_comb begin
    cur_digit  = BLANK_CODE;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (index_reg == IW'(k)) begin
        cur_digit     = digit[k];
        cur_blank     = blank_mask[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  // Registered outputs trail the index by one cycle, so each digit is lit
  // for exactly REFRESH_DIV cycles starting one edge after its index arrives.
  // XOR with the all-off pattern maps the one-hot select onto either polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out_reg    <= BLANK_CODE;
      an_reg         <= {NUM_DIGITS{AN_OFF}};
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= boundary;
      if (!en || cur_blank) begin
        bcd_out_reg <= BLANK_CODE;
        an_reg      <= {NUM_DIGITS{AN_OFF}};
      end else begin
        bcd_out_reg <= cur_digit;
        an_reg      <= {NUM_DIGITS{AN_OFF}} ^ cur_onehot;
      end
    end
  end

  assign bcd_out    = bcd_out_reg;
  assign an         = an_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux (4 digits, 4-cycle slots, active-low anodes).
// Expected {bcd_out, an, frame_done} triples are queued as each stimulus step
// is issued and popped one per clock, sampled on the falling edge.
module tb_seg_scan_mux;

  localparam int N     = 4;
  localparam int DIV   = 4;
  localparam int FRAME = N * DIV;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4*N-1:0] bcd_in = '0;
  logic          load = 1'b0;
  logic          en = 1'b0;
  logic          blank_lz = 1'b0;
  logic [3:0]    bcd_out;
  logic [N-1:0]  an;
  logic          frame_done;

  int errors = 0;
  int checks = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  seg_scan_mux #(
    .NUM_DIGITS    (N),
    .REFRESH_DIV   (DIV),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bcd_in     (bcd_in),
    .load       (load),
    .en         (en),
    .blank_lz   (blank_lz),
    .bcd_out    (bcd_out),
    .an         (an),
    .frame_done (frame_done)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected {bcd, an} for digit k of value, derived from the display rules.
  function automatic logic [7:0] exp_slot(input logic [15:0] value, input int k, input logic blz);
    logic zero_run;
    logic [3:0] onehot;
    zero_run = 1'b1;
    for (int d = N - 1; d >= k; d--) begin
      if (value[4*d +: 4] != 4'h0) zero_run = 1'b0;
    end
    if (blz && k > 0 && zero_run) return {4'hF, 4'b1111};
    onehot = 4'b0001 << k;
    return {value[4*k +: 4], ~onehot};
  endfunction

  task automatic push_exp(input logic [3:0] b, input logic [3:0] a, input logic fd);
    exp_q.push_back({b, a, fd});
  endtask

  task automatic step(input string tag);
    logic [8:0] e;
    @(negedge clk);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: observed empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'({bcd_out, an, frame_done}), 32'(e));
    end
  endtask

  // Checks one whole frame starting at the next edge; optionally pulses load
  // with load_val so that it is captured at the edge after sample load_at.
  task automatic check_frame(input string tag, input logic [15:0] value, input logic blz,
                             input int load_at, input logic [15:0] load_val);
    logic [7:0] e;
    blank_lz = blz;
    $display("frame %s value=%h blank_lz=%b load_at=%0d load_val=%h", tag, value, blz, load_at, load_val);
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < DIV; c++) begin
        e = exp_slot(value, k, blz);
        push_exp(e[7:4], e[3:0], (k == N - 1) && (c == DIV - 1));
      end
    end
    for (int j = 0; j < FRAME; j++) begin
      step(tag);
      load = (j == load_at);
      if (j == load_at) bcd_in = load_val;
    end
  endtask

  initial begin
    // Reset state while rst_n is held low.
    #12;
    check("reset_outputs", 32'({bcd_out, an, frame_done}), 32'({4'hF, 4'b1111, 1'b0}));

    // Release with en=1 and a load of 1234 on the first edge (pending).
    @(negedge clk);
    rst_n  = 1'b1;
    en     = 1'b1;
    load   = 1'b1;
    bcd_in = 16'h1234;
    check_frame("first_frame", 16'h0000, 1'b0, -1, 16'h0);
    check_frame("show_1234", 16'h1234, 1'b0, 5, 16'h5678);
    check_frame("show_5678", 16'h5678, 1'b0, 3, 16'h0007);
    check_frame("blank_0007", 16'h0007, 1'b1, 8, 16'h0000);
    check_frame("blank_0000", 16'h0000, 1'b1, 2, 16'h0A00);
    check_frame("blank_0A00", 16'h0A00, 1'b1, 14, 16'h9999);
    check_frame("boundary_9999", 16'h9999, 1'b0, -1, 16'h0);
    check("pending_clear", 32'(dut.pending_reg), 32'(1'b0));

    // Drop en partway through digit 1.
    $display("transaction en_drop");
    for (int j = 0; j < 6; j++) begin
      push_exp(4'h9, (j < 4) ? 4'b1110 : 4'b1101, 1'b0);
      step("pre_disable");
    end
    en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      push_exp(4'hF, 4'b1111, 1'b0);
      step("disabled");
      load = (j == 1) || (j == 3);
      if (j == 1) bcd_in = 16'h4321;
      if (j == 3) bcd_in = 16'h8765;
    end
    load = 1'b0;
    en   = 1'b1;
    check_frame("reenable_9999", 16'h9999, 1'b0, -1, 16'h0);
    check_frame("last_load_wins", 16'h8765, 1'b0, -1, 16'h0);

    // Asynchronous reset between edges while digit 3 is lit and frame_done is high.
    $display("transaction async_reset");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 32'({bcd_out, an, frame_done}), 32'({4'hF, 4'b1111, 1'b0}));
    @(negedge clk);
    check("held_in_reset", 32'({bcd_out, an, frame_done}), 32'({4'hF, 4'b1111, 1'b0}));
    rst_n = 1'b1;
    check_frame("after_reset", 16'h0000, 1'b0, -1, 16'h0);
    check_frame("after_reset2", 16'h0000, 1'b0, -1, 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
